trap_ctrl: RTL and testbench
============================

# trap_ctrl

Multi-cycle trap and `mret` sequencer for the write-back stage. It accepts a retiring instruction's exception flags, prioritises them, and writes mepc, mcause, mtval and mstatus one at a time over the single CSR port. It then redirects fetch to the mtvec base. On `mret` it restores mstatus and redirects to mepc, stalling the pipeline throughout.

## Interface

**Parameters**
- `XLEN`, 32: data/address width; only 32 is supported.

**Ports**
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: WB holds a retiring instruction this cycle.
- `pc_i` in 32: PC of that instruction.
- `instruction_i` in 32: raw instruction word.
- `addr_i` in 32: faulting data address or misaligned target address.
- `e_inst_addr_mis_i`, `e_illegal_inst_i`, `e_ebreak_i`, `e_ecall_i`, `e_ld_addr_mis_i`, `e_st_addr_mis_i` in 1 each: exception flags.
- `mret_i` in 1: instruction is `mret`.
- `csr_addr_o` out 12: CSR address.
- `csr_we_o` out 1: CSR write strobe.
- `csr_wd_o` out 32: CSR write data.
- `csr_rd_i` in 32: CSR read data, combinational from `csr_addr_o` in the same cycle.
- `stall_o` out 1: freeze IF..WB.
- `flush_o` out 1: kill all younger instructions.
- `redirect_o` out 1: load fetch PC.
- `redirect_pc_o` out 32: new fetch PC.
- `is_exc_taken_o` out 1: one-cycle pulse when a trap is accepted; suppresses the register-file write.

## Operation

**Acceptance (IDLE only)**
- `trap = valid_i & |e_*`; `ret = valid_i & mret_i & ~trap`.
- Inputs are ignored in every state except IDLE.

**Cause priority**, highest first:

| Exception flag | mcause | mtval |
|---|---|---|
| `e_inst_addr_mis_i` | 0 | `addr_i` |
| `e_illegal_inst_i` | 2 | `instruction_i` |
| `e_ebreak_i` | 3 | `pc_i` |
| `e_ecall_i` | 11 | 0 |
| `e_ld_addr_mis_i` | 4 | `addr_i` |
| `e_st_addr_mis_i` | 6 | `addr_i` |

- mcause bit 31 is always 0.
- On accept, `pc_i`, the cause and the tval are captured into internal registers.

**Trap states**
- `T_EPC`: write 0x341 ← `{pc[31:2],2'b00}`.
- `T_CAUSE`: write 0x342 ← cause.
- `T_TVAL`: write 0x343 ← tval.
- `T_RDST`: read 0x300 and capture it.
- `T_WRST`: write 0x300 ← captured value with MPIE(7) = old MIE(3), MIE = 0, MPP(12:11) = 2'b11; other bits unchanged.
- `T_VEC`: read 0x305; `redirect_o = 1`, `redirect_pc_o = {csr_rd_i[31:2],2'b00}` (mode bits ignored); then go to IDLE.

**Return states**
- `R_RDST`: read 0x300 and capture it.
- `R_WRST`: write 0x300 ← captured value with MIE = old MPIE, MPIE = 1, MPP = 2'b11.
- `R_EPC`: read 0x341; `redirect_o = 1`, `redirect_pc_o = {csr_rd_i[31:2],2'b00}`; then go to IDLE.

**Output rules**
- `csr_we_o` is high only in the write states.
- `csr_addr_o` is 0 in IDLE.
- `csr_wd_o` is 0 when not writing.
- `stall_o` = (state ≠ IDLE) | trap | ret.
- `flush_o` = trap | ret, in the IDLE accept cycle only.
- `is_exc_taken_o` = trap, in the IDLE accept cycle only.

**Simultaneous events**
- Exception together with `mret_i`: the trap is taken.
- Several exception flags: only the highest priority is recorded.

**Reset**
- Asynchronous and effective at any state; returns to IDLE and clears the captured registers.
- CSR writes already issued are not undone; the core restarts from its reset vector.

## Timing

- All outputs are 0 while `rst_i` = 0 and in IDLE with no request.
- **Trap** (accept = cycle 0):
  - Cycles 1, 2, 3: mepc, mcause and mtval writes.
  - Cycle 4: mstatus read; cycle 5: mstatus write.
  - Cycle 6: `redirect_o` pulse.
  - Cycle 7: IDLE, `stall_o` low.
  - `stall_o` is high during cycles 0–6 (7 cycles).
- **mret**:
  - Cycle 1: mstatus read; cycle 2: mstatus write.
  - Cycle 3: redirect.
  - Cycle 4: IDLE.
  - `stall_o` is high during cycles 0–3.
- `redirect_o` is exactly one cycle wide, and never coincides with `csr_we_o`.
- A new request is first sampled in the cycle after returning to IDLE (no back-to-back accept).
- State and capture registers update on the rising edge. `stall_o`, `flush_o`, `is_exc_taken_o` and CSR read addressing are combinational from state and inputs.

## Test plan

1. Illegal instruction, pc=0x0000_0104, instr=0xFFFF_FFFF, mtvec=0x0000_0201, mstatus=0x0000_0008 → the following sequence is required:
   - Writes in order: 0x341=0x104, 0x342=2, 0x343=0xFFFF_FFFF, 0x300=0x0000_1880.
   - Redirect to 0x0000_0200 in cycle 6.
   - `stall_o` high for 7 cycles; `flush_o` and `is_exc_taken_o` high in cycle 0 only.
2. `e_ld_addr_mis_i` and `e_illegal_inst_i` both set, addr=0x1003 → the illegal-instruction trap is taken:
   - mcause=2, mtval=instruction.
   - `e_ld_addr_mis_i` alone → mcause=4, mtval=0x1003.
3. `mret` with mstatus=0x0000_1880, mepc=0x0000_0108:
   - Write 0x300=0x0000_1888.
   - Redirect to 0x108 in cycle 3; no writes to mepc, mcause or mtval.
4. `mret_i` together with `e_ecall_i` → trap with mcause=11, mtval=0; no return sequence.
5. `valid_i`=0 with flags set → no stall or CSR activity. Flags asserted during `T_CAUSE` are ignored; the sequence completes unchanged.
6. `rst_i` asserted low in `T_TVAL` → all outputs drop to 0 immediately. After release, a new `ecall` runs the full 7-cycle sequence from IDLE.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap and mret sequencer for write-back: records mepc/mcause/mtval, updates
// mstatus over a single CSR port, then redirects fetch to mtvec or mepc.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instruction_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            e_inst_addr_mis_i,
  input  logic            e_illegal_inst_i,
  input  logic            e_ebreak_i,
  input  logic            e_ecall_i,
  input  logic            e_ld_addr_mis_i,
  input  logic            e_st_addr_mis_i,
  input  logic            mret_i,
  output logic [11:0]     csr_addr_o,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_wd_o,
  input  logic [XLEN-1:0] csr_rd_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            is_exc_taken_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_RDST, T_WRST, T_VEC, R_RDST, R_WRST, R_EPC
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:2]   pc_q, pc_d;
  logic [3:0]        cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   mst_q, mst_d;

  logic              exc_any, trap, ret;
  logic [3:0]        sel_cause;
  logic [XLEN-1:0]   sel_tval;

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] st);
    logic [XLEN-1:0] r;
    r        = st;
    r[7]     = st[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] st);
    logic [XLEN-1:0] r;
    r        = st;
    r[3]     = st[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Accept is gated by reset so every output is quiet while reset is held.
  assign exc_any = e_inst_addr_mis_i | e_illegal_inst_i | e_ebreak_i |
                   e_ecall_i | e_ld_addr_mis_i | e_st_addr_mis_i;
  assign trap    = rst_i & valid_i & exc_any;
  assign ret     = rst_i & valid_i & mret_i & ~exc_any;

  always_comb begin
    sel_cause = 4'd0;
    sel_tval  = '0;
    if (e_inst_addr_mis_i) begin
      sel_cause = 4'd0;
      sel_tval  = addr_i;
    end else if (e_illegal_inst_i) begin
      sel_cause = 4'd2;
      sel_tval  = instruction_i;
    end else if (e_ebreak_i) begin
      sel_cause = 4'd3;
      sel_tval  = pc_i;
    end else if (e_ecall_i) begin
      sel_cause = 4'd11;
      sel_tval  = '0;
    end else if (e_ld_addr_mis_i) begin
      sel_cause = 4'd4;
      sel_tval  = addr_i;
    end else if (e_st_addr_mis_i) begin
      sel_cause = 4'd6;
      sel_tval  = addr_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    mst_d          = mst_q;
    csr_addr_o     = 12'h000;
    csr_we_o       = 1'b0;
    csr_wd_o       = '0;
    redirect_o     = 1'b0;
    redirect_pc_o  = '0;
    stall_o        = 1'b1;
    flush_o        = 1'b0;
    is_exc_taken_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o        = trap | ret;
        flush_o        = trap | ret;
        is_exc_taken_o = trap;
        if (trap) begin
          pc_d    = pc_i[XLEN-1:2];
          cause_d = sel_cause;
          tval_d  = sel_tval;
          state_d = T_EPC;
        end else if (ret) begin
          state_d = R_RDST;
        end
      end
      T_EPC: begin
        csr_addr_o = CSR_MEPC;
        csr_we_o   = 1'b1;
        csr_wd_o   = {pc_q, 2'b00};
        state_d    = T_CAUSE;
      end
      T_CAUSE: begin
        csr_addr_o = CSR_MCAUSE;
        csr_we_o   = 1'b1;
        csr_wd_o   = {{(XLEN-4){1'b0}}, cause_q};
        state_d    = T_TVAL;
      end
      T_TVAL: begin
        csr_addr_o = CSR_MTVAL;
        csr_we_o   = 1'b1;
        csr_wd_o   = tval_q;
        state_d    = T_RDST;
      end
      T_RDST: begin
        csr_addr_o = CSR_MSTATUS;
        mst_d      = csr_rd_i;
        state_d    = T_WRST;
      end
      T_WRST: begin
        csr_addr_o = CSR_MSTATUS;
        csr_we_o   = 1'b1;
        csr_wd_o   = trap_mstatus(mst_q);
        state_d    = T_VEC;
      end
      T_VEC: begin
        // Vector mode bits are ignored: always direct to the base.
        csr_addr_o    = CSR_MTVEC;
        redirect_o    = 1'b1;
        redirect_pc_o = {csr_rd_i[XLEN-1:2], 2'b00};
        state_d       = IDLE;
      end
      R_RDST: begin
        csr_addr_o = CSR_MSTATUS;
        mst_d      = csr_rd_i;
        state_d    = R_WRST;
      end
      R_WRST: begin
        csr_addr_o = CSR_MSTATUS;
        csr_we_o   = 1'b1;
        csr_wd_o   = ret_mstatus(mst_q);
        state_d    = R_EPC;
      end
      R_EPC: begin
        csr_addr_o    = CSR_MEPC;
        redirect_o    = 1'b1;
        redirect_pc_o = {csr_rd_i[XLEN-1:2], 2'b00};
        state_d       = IDLE;
      end
      default: begin
        stall_o = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      mst_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      mst_q   <= mst_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: driver queues expected CSR writes, redirects
// and stall-run summaries; a negedge monitor pops and compares them.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instruction_i, addr_i;
  logic [5:0]  flags;
  logic        mret_i;
  logic [11:0] csr_addr_o;
  logic        csr_we_o;
  logic [31:0] csr_wd_o;
  logic [31:0] csr_rd_i;
  logic        stall_o, flush_o, redirect_o, is_exc_taken_o;
  logic [31:0] redirect_pc_o;

  logic [31:0] m_mstatus, m_mtvec, m_mepc;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .addr_i(addr_i),
    .e_inst_addr_mis_i(flags[5]), .e_illegal_inst_i(flags[4]),
    .e_ebreak_i(flags[3]), .e_ecall_i(flags[2]),
    .e_ld_addr_mis_i(flags[1]), .e_st_addr_mis_i(flags[0]),
    .mret_i(mret_i), .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o),
    .csr_wd_o(csr_wd_o), .csr_rd_i(csr_rd_i), .stall_o(stall_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .is_exc_taken_o(is_exc_taken_o)
  );

  always_comb begin
    csr_rd_i = 32'hDEAD_BEEF;
    case (csr_addr_o)
      12'h300: csr_rd_i = m_mstatus;
      12'h305: csr_rd_i = m_mtvec;
      12'h341: csr_rd_i = m_mepc;
      default: csr_rd_i = 32'hDEAD_BEEF;
    endcase
  end

  // kind 0 = CSR write, 1 = redirect, 2 = end of stall run
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    int          rel;
    int          len;
    int          nf;
    int          ne;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;
  bit   done = 0;

  localparam logic [5:0] F_IMIS = 6'b100000, F_ILL = 6'b010000, F_EBRK = 6'b001000,
                         F_ECALL = 6'b000100, F_LMIS = 6'b000010, F_SMIS = 6'b000001;

  task automatic push_w(input logic [11:0] a, input logic [31:0] d, input int rel);
    exp_t e;
    e = '{kind: 0, addr: a, data: d, rel: rel, len: 0, nf: 0, ne: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] d, input int rel);
    exp_t e;
    e = '{kind: 1, addr: 12'h000, data: d, rel: rel, len: 0, nf: 0, ne: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int len, input int nf, input int ne);
    exp_t e;
    e = '{kind: 2, addr: 12'h000, data: 32'h0, rel: 0, len: len, nf: nf, ne: ne};
    exp_q.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst,
                           input logic [31:0] vec);
    push_w(12'h341, epc, 1);
    push_w(12'h342, cause, 2);
    push_w(12'h343, tval, 3);
    push_w(12'h300, mst, 5);
    push_r(vec, 6);
    push_run(7, 1, 1);
  endtask

  task automatic push_ret(input logic [31:0] mst, input logic [31:0] epc);
    push_w(12'h300, mst, 2);
    push_r(epc, 3);
    push_run(4, 1, 0);
  endtask

  task automatic clr();
    valid_i = 0; flags = '0; mret_i = 0;
    pc_i = '0; instruction_i = '0; addr_i = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ad,
                     input logic [5:0] f, input logic mr);
    @(posedge clk_i); #1;
    valid_i = 1; pc_i = pc; instruction_i = ins; addr_i = ad; flags = f; mret_i = mr;
    @(posedge clk_i); #1;
    clr();
  endtask

  // Monitor
  initial begin : monitor
    int   cyc, st, len, nf, ne, kind;
    bit   in_run;
    exp_t e;
    logic [11:0] a;
    logic [31:0] d;
    cyc = 0; st = 0; len = 0; nf = 0; ne = 0; in_run = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (done) begin
        nvec++;
        if (exp_q.size() != 0) begin
          nmis++;
          $display("FAIL leftover_expectations: %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
      end
      if (stall_o && !in_run) begin
        in_run = 1; st = cyc; len = 0; nf = 0; ne = 0;
      end
      if (in_run && stall_o) begin
        len++;
        nf += int'(flush_o);
        ne += int'(is_exc_taken_o);
      end
      if (csr_we_o || redirect_o) begin
        nvec++;
        if (csr_we_o && redirect_o) begin
          nmis++;
          $display("FAIL we_redirect_overlap: both high at cycle %0d, required exclusive", cyc - st);
        end
        kind = csr_we_o ? 0 : 1;
        a    = csr_we_o ? csr_addr_o : 12'h000;
        d    = csr_we_o ? csr_wd_o : redirect_pc_o;
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++;
          $display("FAIL unexpected_event: kind=%0d addr=%h data=%h, required nothing", kind, a, d);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.addr != a || e.data != d || e.rel != (cyc - st)) begin
            nmis++;
            $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, required kind=%0d addr=%h data=%h cyc=%0d",
                     kind, a, d, cyc - st, e.kind, e.addr, e.data, e.rel);
          end
        end
      end
      if (in_run && !stall_o) begin
        in_run = 0;
        nvec++;
        if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
          nmis++;
          $display("FAIL stall_run: len=%0d flush=%0d exc=%0d ended with no matching expectation",
                   len, nf, ne);
          if (exp_q.size() != 0) e = exp_q.pop_front();
        end else begin
          e = exp_q.pop_front();
          if (e.len != len || e.nf != nf || e.ne != ne) begin
            nmis++;
            $display("FAIL stall_run: got len=%0d flush=%0d exc=%0d, required len=%0d flush=%0d exc=%0d",
                     len, nf, ne, e.len, e.nf, e.ne);
          end
        end
      end
      if (!stall_o) begin
        nvec++;
        if (csr_addr_o != 0 || csr_we_o || csr_wd_o != 0 || redirect_o ||
            redirect_pc_o != 0 || flush_o || is_exc_taken_o) begin
          nmis++;
          $display("FAIL idle_quiet: addr=%h we=%b wd=%h redir=%b rpc=%h flush=%b exc=%b, required all 0",
                   csr_addr_o, csr_we_o, csr_wd_o, redirect_o, redirect_pc_o, flush_o, is_exc_taken_o);
        end
      end
      if (!rst_i) begin
        nvec++;
        if (stall_o) begin
          nmis++;
          $display("FAIL reset_stall: stall=%b, required 0", stall_o);
        end
      end
    end
  end

  // Driver
  initial begin : driver
    clr();
    m_mstatus = 32'h0000_0008; m_mtvec = 32'h0000_0201; m_mepc = 32'h0;
    rst_i = 0;
    valid_i = 1; flags = F_ECALL;
    tick(3);
    clr();
    rst_i = 1;
    tick(2);

    // 1: illegal instruction
    push_trap(32'h104, 32'd2, 32'hFFFF_FFFF, 32'h0000_1880, 32'h200);
    req(32'h0000_0104, 32'hFFFF_FFFF, 32'h0, F_ILL, 0);
    tick(10);

    // 2: priority illegal over load-misaligned, then load-misaligned alone
    push_trap(32'h200, 32'd2, 32'h1234_5678, 32'h0000_1880, 32'h200);
    req(32'h0000_0200, 32'h1234_5678, 32'h1003, F_ILL | F_LMIS, 0);
    tick(10);
    m_mstatus = 32'hFFFF_FFF7;
    push_trap(32'h204, 32'd4, 32'h1003, 32'hFFFF_FF77, 32'h200);
    req(32'h0000_0206, 32'h0, 32'h1003, F_LMIS, 0);
    tick(10);

    // other causes
    m_mstatus = 32'h0; m_mtvec = 32'h0000_8003;
    push_trap(32'h700, 32'd3, 32'h703, 32'h0000_1800, 32'h8000);
    req(32'h0000_0703, 32'h0, 32'h0, F_EBRK, 0);
    tick(10);
    m_mstatus = 32'h8; m_mtvec = 32'h0000_0201;
    push_trap(32'h800, 32'd0, 32'h402, 32'h0000_1880, 32'h200);
    req(32'h0000_0800, 32'h0, 32'h402, F_IMIS | F_EBRK, 0);
    tick(10);
    m_mstatus = 32'h88;
    push_trap(32'h900, 32'd6, 32'h2001, 32'h0000_1880, 32'h200);
    req(32'h0000_0900, 32'h0, 32'h2001, F_SMIS, 0);
    tick(10);

    // 3: mret
    m_mstatus = 32'h0000_1880; m_mepc = 32'h0000_0108;
    push_ret(32'h0000_1888, 32'h108);
    req(32'h0, 32'h3020_0073, 32'h0, 6'b0, 1);
    tick(10);
    m_mstatus = 32'h0000_0008; m_mepc = 32'h0000_010B;
    push_ret(32'h0000_1880, 32'h108);
    req(32'h0, 32'h3020_0073, 32'h0, 6'b0, 1);
    tick(10);

    // 4: mret with ecall -> trap
    m_mstatus = 32'h0000_1888;
    push_trap(32'h300, 32'd11, 32'h0, 32'h0000_1880, 32'h200);
    req(32'h0000_0300, 32'h0, 32'h55, F_ECALL, 1);
    tick(10);

    // 5: flags without valid, then junk during T_CAUSE
    @(posedge clk_i); #1;
    valid_i = 0; flags = 6'b111111; mret_i = 1; addr_i = 32'h1;
    tick(3);
    clr();
    tick(3);
    m_mstatus = 32'h8;
    push_trap(32'h400, 32'd11, 32'h0, 32'h0000_1880, 32'h200);
    req(32'h0000_0400, 32'h0, 32'h0, F_ECALL, 0);
    @(posedge clk_i); #1;
    valid_i = 1; flags = F_ILL; mret_i = 1; pc_i = 32'hABC0; instruction_i = 32'h1;
    @(posedge clk_i); #1;
    clr();
    tick(10);

    // 6: reset during T_TVAL, then a full ecall
    push_w(12'h341, 32'h600, 1);
    push_w(12'h342, 32'd11, 2);
    push_run(3, 1, 1);
    req(32'h0000_0600, 32'h0, 32'h0, F_ECALL, 0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 0;
    tick(2);
    rst_i = 1;
    tick(3);
    push_trap(32'h610, 32'd11, 32'h0, 32'h0000_1880, 32'h200);
    req(32'h0000_0610, 32'h0, 32'h0, F_ECALL, 0);
    tick(10);

    done = 1;
    tick(5);
    $display("FAIL monitor_end: summary not reached");
    $fatal(1, "monitor did not finish");
  end

endmodule
